// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle main control FSM and the MIPS datapath.
// The master side is the controller: it samples the opcode and the memory
// ready handshake and drives every mux select and write enable.
interface mc_control_fsm_if;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  Op, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
               ALUSrcB, state, instr_done, illegal_op
    );

    modport slave (
        output Op, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp,
               ALUSrcB, state, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control unit for the 32-bit MIPS datapath.
// Decodes Op once in DECODE and steps through Moore states, stalling on
// mem_ready in FETCH, MEMRD and MEMWR.
// Build option: define MC_JUMP_EN to add the j instruction (JUMP state);
// without it opcode 000010 is reported as illegal.
module mc_control_fsm (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // Moore part of the outputs. PCWrite/IRWrite in FETCH and instr_done in
    // MEMWR depend on mem_ready and are merged in combinationally below.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrca;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic [1:0] alusrcb;
        logic       instr_done;
    } ctrl_t;

    state_t state_q;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   lw_q;

    function automatic logic op_known(input logic [5:0] op);
        logic k;
        k = 1'b0;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ: k = 1'b1;
`ifdef MC_JUMP_EN
            OP_J:                       k = 1'b1;
`endif
            default:                    k = 1'b0;
        endcase
        return k;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.regwrite   = 1'b1;
                c.memtoreg   = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RCOMP: begin
                c.regdst     = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = 2'b01;
                c.pcwritecond = 1'b1;
                c.pcsource    = 2'b01;
                c.instr_done  = 1'b1;
            end
`ifdef MC_JUMP_EN
            JUMP: begin
                c.pcwrite    = 1'b1;
                c.pcsource   = 2'b10;
                c.instr_done = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [5:0] op,
                                       input logic mr, input logic lw);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:  n = mr ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = EXEC;
                    OP_BEQ:       n = BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         n = JUMP;
`endif
                    default:      n = FETCH;
                endcase
            end
            MEMADR: n = lw ? MEMRD : MEMWR;
            MEMRD:  n = mr ? MEMWB : MEMRD;
            MEMWR:  n = mr ? FETCH : MEMWR;
            EXEC:   n = RCOMP;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    // Next-state selection from the current state, opcode and handshake.
    always_comb begin
        state_nxt = next_of(state_q, bus.Op, bus.mem_ready, lw_q);
    end

    // State register; Moore outputs are registered from the next state so
    // they always match the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode_ctrl(FETCH);
            lw_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= decode_ctrl(state_nxt);
            if (state_q == DECODE) begin
                lw_q <= (bus.Op == OP_LW);
            end
        end
    end

    assign bus.PCWrite     = ctrl_q.pcwrite | ((state_q == FETCH) & bus.mem_ready);
    assign bus.IRWrite     = (state_q == FETCH) & bus.mem_ready;
    assign bus.PCWriteCond = ctrl_q.pcwritecond;
    assign bus.IorD        = ctrl_q.iord;
    assign bus.MemRead     = ctrl_q.memread;
    assign bus.MemWrite    = ctrl_q.memwrite;
    assign bus.MemtoReg    = ctrl_q.memtoreg;
    assign bus.ALUSrcA     = ctrl_q.alusrca;
    assign bus.RegWrite    = ctrl_q.regwrite;
    assign bus.RegDst      = ctrl_q.regdst;
    assign bus.PCSource    = ctrl_q.pcsource;
    assign bus.ALUOp       = ctrl_q.aluop;
    assign bus.ALUSrcB     = ctrl_q.alusrcb;
    assign bus.instr_done  = ctrl_q.instr_done | ((state_q == MEMWR) & bus.mem_ready);
    assign bus.illegal_op  = (state_q == DECODE) & ~op_known(bus.Op);
    assign bus.state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each generated instruction pushes its
// per-cycle stimulus together with the expected state and control vector.
module tb_mc_control_fsm;

    logic clk;
    logic reset;

    mc_control_fsm_if bus();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctrl;
    } rec_t;

    rec_t  exp_q[$];
    string tag_q[$];

    int nchecks = 0;
    int nerrors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        bit k;
        k = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100);
`ifdef MC_JUMP_EN
        if (op == 6'b000010) k = 1'b1;
`endif
        return k;
    endfunction

    // Reference control vector:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,
    //  RegWrite,RegDst,PCSource[1:0],ALUOp[1:0],ALUSrcB[1:0],instr_done,illegal_op}
    function automatic logic [17:0] exp_ctrl(input int s, input logic mr, input logic ill);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, done, illg;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, done, illg} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (s)
            0: begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1: begin asb = 2'b11; illg = ill; end
            2: begin asa = 1; asb = 2'b10; end
            3: begin mrd = 1; iord = 1; end
            4: begin rw = 1; m2r = 1; done = 1; end
            5: begin mwr = 1; iord = 1; done = mr; end
            6: begin asa = 1; aop = 2'b10; end
            7: begin rd = 1; rw = 1; done = 1; end
            8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            9: begin pcw = 1; pcs = 2'b10; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, aop, asb, done, illg};
    endfunction

    task automatic push(input string tag, input logic rst, input logic [5:0] op,
                        input logic mr, input int st);
        rec_t r;
        r.rst  = rst;
        r.op   = op;
        r.mr   = mr;
        r.st   = st[3:0];
        r.ctrl = exp_ctrl(st, mr, (st == 1) && !legal(op));
        exp_q.push_back(r);
        tag_q.push_back($sformatf("%s.s%0d", tag, st));
    endtask

    // Queue one full instruction; nstall low-mem_ready cycles are inserted
    // in front of the completing cycle of state stall_st.
    task automatic add_instr(input string tag, input logic [5:0] op,
                             input int stall_st, input int nstall);
        int path[$];
        path = '{0, 1};
        case (op)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b000100: path = '{0, 1, 8};
`ifdef MC_JUMP_EN
            6'b000010: path = '{0, 1, 9};
`endif
            default:   path = '{0, 1};
        endcase
        foreach (path[i]) begin
            if (path[i] == stall_st) begin
                for (int k = 0; k < nstall; k++) push(tag, 1'b0, op, 1'b0, path[i]);
            end
            push(tag, 1'b0, op, 1'b1, path[i]);
        end
    endtask

    initial begin
        rec_t  r;
        string t;

        reset = 1'b1;
        bus.Op = 6'b000000;
        bus.mem_ready = 1'b1;

        // Reset held with mem_ready high: FETCH outputs with PCWrite=IRWrite=1.
        push("reset", 1'b1, 6'b000000, 1'b1, 0);
        add_instr("lw",      6'b100011, -1, 0);
        add_instr("sw_stall", 6'b101011, 5, 3);
        add_instr("rtype",   6'b000000, -1, 0);
        add_instr("beq",     6'b000100, -1, 0);
        add_instr("illegal", 6'b111111, -1, 0);
        add_instr("j",       6'b000010, -1, 0);
        add_instr("lw_fst",  6'b100011, 0, 2);
        add_instr("lw_rst",  6'b100011, 3, 2);
        add_instr("sw",      6'b101011, -1, 0);
        // Reset in MEMRD with mem_ready high: reset wins, next state FETCH.
        push("rst_mid", 1'b0, 6'b100011, 1'b1, 0);
        push("rst_mid", 1'b0, 6'b100011, 1'b1, 1);
        push("rst_mid", 1'b0, 6'b100011, 1'b1, 2);
        push("rst_mid", 1'b1, 6'b100011, 1'b1, 3);
        push("rst_mid", 1'b0, 6'b100011, 1'b0, 0);
        add_instr("after",   6'b000100, 0, 1);

        repeat (2) @(posedge clk);

        while (exp_q.size() > 0) begin
            @(negedge clk);
            r = exp_q.pop_front();
            t = tag_q.pop_front();
            reset = r.rst;
            bus.Op = r.op;
            bus.mem_ready = r.mr;
            #1;
            chk({t, ".state"}, {28'd0, bus.state}, {28'd0, r.st});
            chk({t, ".ctrl"},
                {14'd0, bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                 bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.ALUSrcA,
                 bus.RegWrite, bus.RegDst, bus.PCSource, bus.ALUOp,
                 bus.ALUSrcB, bus.instr_done, bus.illegal_op},
                {14'd0, r.ctrl});
        end

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
